// File: rtl/irq_ctrl_n.sv
// -----------------------------------------------------------------------------
// irq_ctrl_n -- external/device interrupt controller on the AVR 6-bit I/O bus.
//
// Register map (relative to BASE_ADR):
//   +0  MSK   pin interrupt enables          [PIN_IRQS-1:0]
//   +1  FLG   sticky pin flags (write-1-to-clear; level pins read ~pin)
//   +2  MODE  2-bit sense mode per pin       [2*PIN_IRQS-1:0]
//   +3  DMSK  device line enables            [DEV_IRQS-1:0]
//             (present only when IRQ_CTRL_DEV_MASK_EN is defined)
//
// Sense modes: 00 low level, 01 any change, 10 falling, 11 rising.
// Pins pass through a two-flop synchroniser and a previous-sample stage.
// Edge detection compares the last two synchronised samples. A short
// warm-up counter after reset keeps the first 0->1 transition of the
// synchronisers from being taken as a real edge.
//
// Optional feature macro: IRQ_CTRL_DEV_MASK_EN (device mask register).
// -----------------------------------------------------------------------------
module irq_ctrl_n #(
    parameter int         PIN_IRQS = 2,       // 1..4
    parameter int         DEV_IRQS = 3,       // 1..8
    parameter logic [5:0] BASE_ADR = 6'h38
) (
    input  logic                         clk_i,
    input  logic                         rst_i,       // async, active low
    input  logic                         ena_i,
    input  logic [5:0]                   adr_i,
    input  logic [7:0]                   data_i,
    output logic [7:0]                   data_o,
    input  logic                         re_i,
    input  logic                         we_i,
    output logic                         selected_o,
    input  logic [PIN_IRQS-1:0]          pin_irq_i,
    input  logic [DEV_IRQS-1:0]          dev_irq_i,
    input  logic [PIN_IRQS-1:0]          irq_ack_i,
    output logic [PIN_IRQS+DEV_IRQS-1:0] ext_irq_o
);

    // -------------------------------------------------------------------------
    // Address map and sense-mode encoding
    // -------------------------------------------------------------------------
    localparam logic [5:0] MSK_ADR  = BASE_ADR;
    localparam logic [5:0] FLG_ADR  = BASE_ADR + 6'd1;
    localparam logic [5:0] MODE_ADR = BASE_ADR + 6'd2;
`ifdef IRQ_CTRL_DEV_MASK_EN
    localparam logic [5:0] DMSK_ADR = BASE_ADR + 6'd3;
`endif

    typedef enum logic [1:0] {
        SENSE_LOW  = 2'b00,
        SENSE_ANY  = 2'b01,
        SENSE_FALL = 2'b10,
        SENSE_RISE = 2'b11
    } sense_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PIN_IRQS-1:0]   pin_s1;
    logic [PIN_IRQS-1:0]   pin_s2;
    logic [PIN_IRQS-1:0]   pin_prev;
    logic [1:0]            warm_cnt;

    logic [PIN_IRQS-1:0]   msk_q;
    logic [PIN_IRQS-1:0]   flg_q;
    logic [2*PIN_IRQS-1:0] mode_q;
    logic [DEV_IRQS-1:0]   dmsk;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic wr_en;
    logic msk_hit;
    logic flg_hit;
    logic mode_hit;
    logic dmsk_hit;
    logic any_hit;

    assign wr_en    = we_i & ena_i;
    assign msk_hit  = (adr_i == MSK_ADR);
    assign flg_hit  = (adr_i == FLG_ADR);
    assign mode_hit = (adr_i == MODE_ADR);
`ifdef IRQ_CTRL_DEV_MASK_EN
    assign dmsk_hit = (adr_i == DMSK_ADR);
`else
    assign dmsk_hit = 1'b0;
`endif
    assign any_hit  = msk_hit | flg_hit | mode_hit | dmsk_hit;

    // Write data above the implemented register widths is intentionally dropped.
    logic data_unused;
    assign data_unused = &{1'b0, data_i};

    // -------------------------------------------------------------------------
    // Pin synchroniser and edge history; free-running, independent of ena_i
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pin_s1   <= '0;
            pin_s2   <= '0;
            pin_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments make the three stages shift by
            // exactly one flop per clock regardless of statement order.
            pin_s1   <= pin_irq_i;
            pin_s2   <= pin_s1;
            pin_prev <= pin_s2;
        end
    end

    // Warm-up counter: saturates at 3, edge flags are blocked until then
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            warm_cnt <= 2'd0;
        end else if (warm_cnt != 2'd3) begin
            warm_cnt <= warm_cnt + 2'd1;
        end
    end

    logic warm_done;
    assign warm_done = (warm_cnt == 2'd3);

    // -------------------------------------------------------------------------
    // Per-pin sense logic: flag next-state, readable flag view, pin request
    // -------------------------------------------------------------------------
    logic [PIN_IRQS-1:0] level_mode;
    logic [PIN_IRQS-1:0] edge_hit;
    logic [PIN_IRQS-1:0] flg_set;
    logic [PIN_IRQS-1:0] flg_clr;
    logic [PIN_IRQS-1:0] flg_next;
    logic [PIN_IRQS-1:0] flg_view;
    logic [PIN_IRQS-1:0] pin_req;

    // Decode sense mode per pin and form flag update (set beats clear)
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the loop or case can leave a value held (no latch).
        level_mode = '0;
        edge_hit   = '0;
        flg_set    = '0;
        flg_clr    = irq_ack_i | ((wr_en && flg_hit) ? data_i[PIN_IRQS-1:0] : '0);
        flg_next   = '0;
        flg_view   = '0;
        pin_req    = '0;
        for (int i = 0; i < PIN_IRQS; i++) begin
            case (sense_e'(mode_q[2*i +: 2]))
                SENSE_LOW:  level_mode[i] = 1'b1;
                SENSE_ANY:  edge_hit[i]   = pin_s2[i] ^ pin_prev[i];
                SENSE_FALL: edge_hit[i]   = pin_prev[i] & ~pin_s2[i];
                SENSE_RISE: edge_hit[i]   = ~pin_prev[i] & pin_s2[i];
                default:    edge_hit[i]   = 1'b0;
            endcase

            flg_set[i] = edge_hit[i] & warm_done;

            if (level_mode[i]) begin
                // Level pins keep no sticky state; the live pin is the request.
                flg_next[i] = 1'b0;
                flg_view[i] = ~pin_s2[i];
            end else begin
                flg_next[i] = flg_set[i] | (flg_q[i] & ~flg_clr[i]);
                flg_view[i] = flg_q[i];
            end

            pin_req[i] = msk_q[i] & flg_view[i];
        end
    end

    // -------------------------------------------------------------------------
    // Control registers: MSK, MODE, FLG
    // -------------------------------------------------------------------------
    // Bus writes to MSK/MODE and per-clock flag update
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: every control register has a defined reset value; there is
            // no storage array here that could be left unreset.
            msk_q  <= '0;
            mode_q <= '0;
            flg_q  <= '0;
        end else begin
            if (wr_en && msk_hit) begin
                msk_q <= data_i[PIN_IRQS-1:0];
            end
            if (wr_en && mode_hit) begin
                mode_q <= data_i[2*PIN_IRQS-1:0];
            end
            flg_q <= flg_next;
        end
    end

`ifdef IRQ_CTRL_DEV_MASK_EN
    // Device mask register, resets to all lines enabled
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dmsk <= '1;
        end else if (wr_en && dmsk_hit) begin
            dmsk <= data_i[DEV_IRQS-1:0];
        end
    end
`else
    assign dmsk = '1;
`endif

    // -------------------------------------------------------------------------
    // Read mux and bus outputs
    // -------------------------------------------------------------------------
    logic [7:0] rd_data;

    // Select the addressed register, zero-extended to the bus width
    always_comb begin
        rd_data = 8'h00;
        case (adr_i)
            MSK_ADR:  rd_data = 8'(msk_q);
            FLG_ADR:  rd_data = 8'(flg_view);
            MODE_ADR: rd_data = 8'(mode_q);
`ifdef IRQ_CTRL_DEV_MASK_EN
            DMSK_ADR: rd_data = 8'(dmsk);
`endif
            default:  rd_data = 8'h00;
        endcase
    end

    // Outputs are forced low for the whole time reset is held, which covers
    // the level-mode pins whose reset-state synchronisers read as "low".
    assign data_o     = (rst_i && re_i && any_hit) ? rd_data : 8'h00;
    assign selected_o = rst_i & (re_i | we_i) & any_hit;
    assign ext_irq_o  = rst_i ? {dev_irq_i & dmsk, pin_req} : '0;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl_n -- directed self-checking bench for irq_ctrl_n (defaults:
// PIN_IRQS=2, DEV_IRQS=3, BASE_ADR=6'h38). Honours IRQ_CTRL_DEV_MASK_EN.
// -----------------------------------------------------------------------------
module tb_irq_ctrl_n;

    localparam logic [5:0] MSK_A  = 6'h38;
    localparam logic [5:0] FLG_A  = 6'h39;
    localparam logic [5:0] MODE_A = 6'h3A;
    localparam logic [5:0] DMSK_A = 6'h3B;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       ena_i;
    logic [5:0] adr_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       re_i;
    logic       we_i;
    logic       selected_o;
    logic [1:0] pin_irq_i;
    logic [2:0] dev_irq_i;
    logic [1:0] irq_ack_i;
    logic [4:0] ext_irq_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rd;

    irq_ctrl_n dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ena_i      (ena_i),
        .adr_i      (adr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .re_i       (re_i),
        .we_i       (we_i),
        .selected_o (selected_o),
        .pin_irq_i  (pin_irq_i),
        .dev_irq_i  (dev_irq_i),
        .irq_ack_i  (irq_ack_i),
        .ext_irq_o  (ext_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d, input logic en);
        adr_i  = a;
        data_i = d;
        ena_i  = en;
        we_i   = 1'b1;
        tick();
        we_i   = 1'b0;
        ena_i  = 1'b1;
        data_i = 8'h00;
        adr_i  = 6'h00;
    endtask

    task automatic io_read(input logic [5:0] a, output logic [7:0] d);
        adr_i = a;
        re_i  = 1'b1;
        #1;
        d     = data_o;
        re_i  = 1'b0;
        adr_i = 6'h00;
    endtask

    initial begin
        rst_i     = 1'b0;
        ena_i     = 1'b1;
        adr_i     = 6'h00;
        data_i    = 8'h00;
        re_i      = 1'b0;
        we_i      = 1'b0;
        pin_irq_i = 2'b11;
        dev_irq_i = 3'b111;
        irq_ack_i = 2'b00;

        // ---- Reset state: all outputs low even with devices requesting ----
        #12;
        adr_i = FLG_A;
        re_i  = 1'b1;
        #1;
        check("rst_ext",  8'(ext_irq_o), 8'h00);
        check("rst_data", data_o, 8'h00);
        check("rst_sel",  8'(selected_o), 8'h00);
        re_i      = 1'b0;
        adr_i     = 6'h00;
        dev_irq_i = 3'b000;

        // ---- Warm-up guard: pins high at release, any-change mode ----
        tick();
        rst_i = 1'b1;
        io_write(MODE_A, 8'h05, 1'b1);
        io_write(MSK_A,  8'h03, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("warm_ext", 8'(ext_irq_o), 8'h00);
            io_read(FLG_A, rd);
            check("warm_flg", rd, 8'h00);
        end
        io_read(MSK_A, rd);
        check("rd_msk", rd, 8'h03);
        io_read(MODE_A, rd);
        check("rd_mode", rd, 8'h05);
        adr_i = 6'h37;
        re_i  = 1'b1;
        #1;
        check("undec_data", data_o, 8'h00);
        check("undec_sel",  8'(selected_o), 8'h00);
        re_i  = 1'b0;
        adr_i = 6'h00;

        // ---- Pin0 falling edge, latency and acknowledge ----
        io_write(MODE_A, 8'h02, 1'b1);
        io_write(MSK_A,  8'h01, 1'b1);
        pin_irq_i = 2'b10;
        tick();
        tick();
        check("fall_k1", 8'(ext_irq_o), 8'h00);
        tick();
        check("fall_k2", 8'(ext_irq_o), 8'h01);
        io_read(FLG_A, rd);
        check("fall_flg", rd, 8'h01);
        irq_ack_i = 2'b01;
        tick();
        irq_ack_i = 2'b00;
        check("ack_ext", 8'(ext_irq_o), 8'h00);
        io_read(FLG_A, rd);
        check("ack_flg", rd, 8'h00);

        // ---- Masked rising edge on pin1, then unmask ----
        pin_irq_i = 2'b01;
        tick();
        tick();
        tick();
        io_write(MSK_A,  8'h00, 1'b1);
        io_write(MODE_A, 8'h0C, 1'b1);
        io_read(FLG_A, rd);
        check("rise_pre_flg", rd, 8'h00);
        pin_irq_i = 2'b11;
        tick();
        tick();
        tick();
        io_read(FLG_A, rd);
        check("rise_flg", rd, 8'h02);
        check("rise_masked", 8'(ext_irq_o), 8'h00);
        io_write(MSK_A, 8'h02, 1'b1);
        check("rise_unmask", 8'(ext_irq_o), 8'h02);
        io_write(FLG_A, 8'h02, 1'b1);
        check("w1c_ext", 8'(ext_irq_o), 8'h00);
        io_read(FLG_A, rd);
        check("w1c_flg", rd, 8'h00);

        // ---- Set wins over a coincident write-1-to-clear ----
        io_write(MODE_A, 8'h02, 1'b1);
        io_write(MSK_A,  8'h01, 1'b1);
        pin_irq_i = 2'b10;
        tick();
        tick();
        io_write(FLG_A, 8'h01, 1'b1);
        io_read(FLG_A, rd);
        check("setwin_flg", rd, 8'h01);
        check("setwin_ext", 8'(ext_irq_o), 8'h01);
        io_write(FLG_A, 8'h01, 1'b0);
        io_read(FLG_A, rd);
        check("noena_flg", rd, 8'h01);
        io_write(FLG_A, 8'h01, 1'b1);
        io_read(FLG_A, rd);
        check("ena_clr_flg", rd, 8'h00);

        // ---- Level mode: pin0 held low, ack and write ignored ----
        io_write(MODE_A, 8'h00, 1'b1);
        io_write(MSK_A,  8'h01, 1'b1);
        check("lvl_ext", 8'(ext_irq_o), 8'h01);
        io_read(FLG_A, rd);
        check("lvl_flg", rd, 8'h01);
        irq_ack_i = 2'b01;
        tick();
        irq_ack_i = 2'b00;
        check("lvl_ack_ext", 8'(ext_irq_o), 8'h01);
        io_write(FLG_A, 8'h01, 1'b1);
        io_read(FLG_A, rd);
        check("lvl_w1c_flg", rd, 8'h01);
        pin_irq_i = 2'b11;
        tick();
        check("lvl_rel1", 8'(ext_irq_o), 8'h01);
        tick();
        check("lvl_rel2", 8'(ext_irq_o), 8'h00);

        // ---- Device mask register ----
        dev_irq_i = 3'b111;
        adr_i     = DMSK_A;
        data_i    = 8'h05;
        ena_i     = 1'b1;
        we_i      = 1'b1;
        #1;
`ifdef IRQ_CTRL_DEV_MASK_EN
        check("dmsk_sel", 8'(selected_o), 8'h01);
`else
        check("dmsk_sel", 8'(selected_o), 8'h00);
`endif
        tick();
        we_i   = 1'b0;
        data_i = 8'h00;
        adr_i  = 6'h00;
        io_read(DMSK_A, rd);
`ifdef IRQ_CTRL_DEV_MASK_EN
        check("dmsk_ext", 8'(ext_irq_o[4:2]), 8'h05);
        check("dmsk_rd",  rd, 8'h05);
`else
        check("dmsk_ext", 8'(ext_irq_o[4:2]), 8'h07);
        check("dmsk_rd",  rd, 8'h00);
`endif
        dev_irq_i = 3'b010;
        #1;
`ifdef IRQ_CTRL_DEV_MASK_EN
        check("dev_comb", 8'(ext_irq_o[4:2]), 8'h00);
`else
        check("dev_comb", 8'(ext_irq_o[4:2]), 8'h02);
`endif
        dev_irq_i = 3'b000;

        // ---- Asynchronous reset mid-operation clears a pending flag ----
        io_write(MODE_A, 8'h02, 1'b1);
        io_write(MSK_A,  8'h01, 1'b1);
        pin_irq_i = 2'b10;
        tick();
        tick();
        tick();
        check("prerst_ext", 8'(ext_irq_o), 8'h01);
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst_ext", 8'(ext_irq_o), 8'h00);
        tick();
        rst_i = 1'b1;
        io_read(MSK_A, rd);
        check("postrst_msk", rd, 8'h00);
        io_read(MODE_A, rd);
        check("postrst_mode", rd, 8'h00);
        io_write(MODE_A, 8'h02, 1'b1);
        io_write(MSK_A,  8'h01, 1'b1);
        tick();
        tick();
        tick();
        check("postrst_ext", 8'(ext_irq_o), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_ctrl_n.md
Name: irq_ctrl_n

Overview:
- Parametrised successor of the fixed 2-pin/3-device external interrupt controller on the AVR I/O bus.
- Handles PIN_IRQS external pins, each with a programmable sense mode (low level, any change, falling, rising), a mask bit and a sticky flag.
- Passes DEV_IRQS peripheral request lines through to the core.
- Sits beside IOPort/WBControl on the 6-bit io_adr bus and drives the core's irq_lines vector.

Parameters:
- PIN_IRQS, 2, number of external pin interrupts; legal range 1..4 (mode register holds 2 bits per pin).
- DEV_IRQS, 3, number of device interrupt lines; legal range 1..8.
- BASE_ADR, 6'h38, I/O address of MSK; FLG=BASE_ADR+1, MODE=BASE_ADR+2, DMSK=BASE_ADR+3 (optional feature only).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- ena_i  in  1  CPU clock enable; qualifies register writes
- adr_i  in  6  I/O address
- data_i  in  8  write data from core
- data_o  out  8  read data to core
- re_i  in  1  I/O read strobe
- we_i  in  1  I/O write strobe
- selected_o  out  1  block addressed (drives the I/O read mux)
- pin_irq_i  in  PIN_IRQS  asynchronous external pins
- dev_irq_i  in  DEV_IRQS  level requests from peripherals
- irq_ack_i  in  PIN_IRQS  core acknowledge, one per pin vector
- ext_irq_o  out  PIN_IRQS+DEV_IRQS  [PIN_IRQS-1:0] pin requests, upper bits device requests

Behaviour:
- Reset (rst_i=0, asynchronous): MSK=0, FLG=0, MODE=0, DMSK=all ones, synchronisers/prev=0, warm-up counter=0. Outputs: ext_irq_o=0, data_o=0, selected_o=0.
- Each pin is double-flop synchronised (s1, s2), then registered into prev. Synchronisers run every clock, independent of ena_i.
- Warm-up: a 2-bit counter increments each clock after reset and saturates at 3. Edge flags cannot set until it reads 3, which suppresses the spurious edge from the reset-to-0 synchronisers.
- MODE bits [2i+1:2i] select the sense mode for pin i:
  - 00: low level.
  - 01: any change (s2!=prev).
  - 10: falling (prev & ~s2).
  - 11: rising (~prev & s2).
- Edge modes:
  - FLG[i] sets on a qualifying edge.
  - FLG[i] clears on irq_ack_i[i], or on a FLG write with data_i[i]=1 while ena_i=1.
  - Set and clear in the same cycle: set wins.
- Level mode: FLG[i] is held 0. A FLG read returns ~s2[i] for that bit. Ack and write-1 have no effect.
- Latency: pin change sampled at edge k causes FLG/ext_irq_o to assert after edge k+2.
- Pin request: ext_irq_o[i] = MSK[i] & (level mode ? ~s2[i] : FLG[i]). This is combinational from registers.
- Masking does not block flag setting. A pending flag appears as soon as MSK[i] is written 1.
- Changing MODE does not clear FLG.
- Device requests: ext_irq_o[PIN_IRQS+j] = dev_irq_i[j] & DMSK[j]. There is no registering, so zero latency.
- Writes take effect on clock when we_i & ena_i & address match. Only the implemented low bits are stored; unimplemented bits read 0.
- data_o: the addressed register when re_i & address match, else 0.
- selected_o: high when (re_i|we_i) and adr_i is a decoded address.
- Reset asserted mid-operation clears pending flags immediately.

Optional Feature:
- Macro: IRQ_CTRL_DEV_MASK_EN.
- Defined: DMSK register at BASE_ADR+3 (read/write, DEV_IRQS bits, reset all ones) gates the device lines.
- Undefined: DMSK is a constant all-ones, BASE_ADR+3 is not decoded, and selected_o stays 0 for that address.

Test Plan:
- Reset release with pin_irq_i=2'b11 and MODE=01 written → FLG stays 00 and ext_irq_o=0 for 10 cycles (warm-up guard).
- MODE=8'h02 (pin0 falling), MSK=1; drive pin0 1→0 at edge k → ext_irq_o[0]=1 after edge k+2; pulse irq_ack_i[0] → FLG=0 and ext_irq_o[0]=0 next cycle.
- MSK=0, rising edge on pin1 (MODE=8'h0C) → FLG reads 8'h02 and ext_irq_o[1]=0; write MSK=8'h02 → ext_irq_o[1]=1 immediately.
- Qualifying edge coincides with a FLG write of 8'h01 (ena_i=1) → FLG[0] remains 1 (set wins).
- Level mode, MSK=1, pin0 held low → ext_irq_o[0]=1 and FLG read bit0=1 while low; release high → 0 after 2 clocks; ack ignored.
- IRQ_CTRL_DEV_MASK_EN defined: write DMSK=8'h05, dev_irq_i=3'b111 → ext_irq_o[4:2]=3'b101. Undefined: same write → selected_o=0 and ext_irq_o[4:2]=3'b111.
